// File: rtl/tmr_pkg.sv
// tmr_pkg: shared state encoding, replica-count check and replica packing helper
package tmr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, FIX = 2'd2} state_t;
  function automatic bit m_ok(input int m);
    return m >= 3 && m % 2 == 1;
  endfunction
  function automatic int rep_lsb(input int k, input int n);
    return k * n;
  endfunction
endpackage

// File: rtl/mvtr.sv
// mvtr: bitwise M-way majority voter over a packed replica bundle, flags any disagreeing replica
module mvtr
  import tmr_pkg::*;
#(
  parameter int M = 3,
  parameter int N = 32
) (
  input  logic [M*N-1:0] vtr_i,
  output logic [N-1:0]   vtr_o,
  output logic           warn_o
);
  function automatic logic maj(input logic [M-1:0] v);
    int c;
    c = 0;
    for (int k = 0; k < M; k++) c = c + int'(v[k]);
    return c > M / 2;
  endfunction
  for (genvar b = 0; b < N; b++) begin : g_bit
    logic [M-1:0] col;
    always_comb for (int k = 0; k < M; k++) col[k] = vtr_i[rep_lsb(k, N) + b];
    assign vtr_o[b] = maj(col);
  end
  always_comb begin
    warn_o = 1'b0;
    for (int k = 0; k < M; k++) warn_o = warn_o | (vtr_i[rep_lsb(k, N) +: N] != vtr_o);
  end
endmodule

// File: rtl/tmr_scrub_reg.sv
// tmr_scrub_reg: M-way replicated register with periodic vote-and-repair scrubbing.
// Define TMR_SCRUB_FAULT_INJ_EN to enable per-replica fault injection via inj_i/inj_mask_i.
module tmr_scrub_reg
  import tmr_pkg::*;
#(
  parameter int M            = 3,
  parameter int N            = 32,
  parameter int SCRUB_PERIOD = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [N-1:0]     wr_data_i,
  input  logic             clr_i,
  input  logic [M-1:0]     inj_i,
  input  logic [N-1:0]     inj_mask_i,
  output logic [M*N-1:0]   rep_o,
  output logic [N-1:0]     data_o,
  output logic             warn_o,
  output logic [M-1:0]     err_rep_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             busy_o
);
  localparam int TW = $clog2(SCRUB_PERIOD);
  if (!m_ok(M) || SCRUB_PERIOD < 2) begin : g_bad_param
    $error("tmr_scrub_reg: M must be odd and >= 3, SCRUB_PERIOD must be >= 2");
  end
  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [M*N-1:0]   rep_q, rep_nxt;
  logic [N-1:0]     vote_q;
  logic [M-1:0]     mm, mm_q;
  assign rep_o  = rep_q;
  assign busy_o = state_q != IDLE;
  mvtr #(.M(M), .N(N)) u_vtr (.vtr_i(rep_q), .vtr_o(data_o), .warn_o(warn_o));
  always_comb for (int k = 0; k < M; k++) mm[k] = rep_q[rep_lsb(k, N) +: N] != data_o;
  // Later assignments win: repair, then injection, then a write
  always_comb begin
    rep_nxt = rep_q;
    for (int k = 0; k < M; k++) begin
      if (state_q == FIX && mm_q[k]) rep_nxt[rep_lsb(k, N) +: N] = vote_q;
`ifdef TMR_SCRUB_FAULT_INJ_EN
      if (inj_i[k]) rep_nxt[rep_lsb(k, N) +: N] = rep_q[rep_lsb(k, N) +: N] ^ inj_mask_i;
`endif
    end
    if (wr_en_i) rep_nxt = {M{wr_data_i}};
  end
`ifndef TMR_SCRUB_FAULT_INJ_EN
  logic unused_inj;
  assign unused_inj = ^{inj_i, inj_mask_i};
`endif
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_q     <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      vote_q    <= '0;
      mm_q      <= '0;
      err_rep_o <= '0;
      err_cnt_o <= '0;
    end else begin
      rep_q <= rep_nxt;
      if (wr_en_i) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= timer_q == TW'(SCRUB_PERIOD - 1) ? CHECK : IDLE;
            timer_q <= timer_q == TW'(SCRUB_PERIOD - 1) ? '0 : timer_q + 1'b1;
          end
          CHECK: begin
            vote_q  <= data_o;
            mm_q    <= mm;
            state_q <= |mm ? FIX : IDLE;
          end
          FIX: begin
            err_rep_o <= err_rep_o | mm_q;
            err_cnt_o <= &err_cnt_o ? err_cnt_o : err_cnt_o + 1'b1;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
      if (clr_i) begin
        err_cnt_o <= '0;
        err_rep_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_tmr_scrub_reg.sv
// tb_tmr_scrub_reg: directed checks of write, scrub timing, repair, counters, clear and async reset.
// Upsets are planted by forcing the replica register, so repair is exercised without TMR_SCRUB_FAULT_INJ_EN.
module tb_tmr_scrub_reg;
  logic        clk = 0, rst_n = 0, wr_en = 0, clr = 0;
  logic [31:0] wr_data = '0, inj_mask = '0;
  logic [2:0]  inj = '0;
  logic [95:0] rep;
  logic [31:0] data;
  logic        warn, busy;
  logic [2:0]  err_rep;
  logic [15:0] err_cnt;
  logic        rst_n2 = 0, wr2 = 0, clr2 = 0;
  logic [7:0]  wr_data2 = '0, mask2 = '0;
  logic [2:0]  inj2 = '0;
  logic [23:0] rep2;
  logic [7:0]  data2;
  logic        warn2, busy2;
  logic [2:0]  err_rep2;
  logic [1:0]  err_cnt2;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  tmr_scrub_reg dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data), .clr_i(clr),
    .inj_i(inj), .inj_mask_i(inj_mask), .rep_o(rep), .data_o(data), .warn_o(warn),
    .err_rep_o(err_rep), .err_cnt_o(err_cnt), .busy_o(busy)
  );
  tmr_scrub_reg #(.M(3), .N(8), .SCRUB_PERIOD(4), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n2), .wr_en_i(wr2), .wr_data_i(wr_data2), .clr_i(clr2),
    .inj_i(inj2), .inj_mask_i(mask2), .rep_o(rep2), .data_o(data2), .warn_o(warn2),
    .err_rep_o(err_rep2), .err_cnt_o(err_cnt2), .busy_o(busy2)
  );
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic write(input logic [31:0] d);
    wr_en = 1; wr_data = d; tick(1); wr_en = 0;
  endtask
  task automatic corrupt(input logic [95:0] v);
    force dut.rep_q = v; #1; release dut.rep_q;
  endtask
  task automatic corrupt2(input logic [23:0] v);
    force dut2.rep_q = v; #1; release dut2.rep_q;
  endtask
  initial begin
    tick(2);
    chk("rst_rep", rep, 0);
    chk("rst_data", data, 0);
    chk("rst_warn", warn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_err_rep", err_rep, 0);
    rst_n = 1; rst_n2 = 1;
    write(32'hFF);
    chk("wr_rep", rep, {3{32'hFF}});
    chk("wr_data", data, 32'hFF);
    chk("wr_warn", warn, 0);
    tick(15); chk("idle_before_period", busy, 0);
    tick(1);  chk("check_at_period", busy, 1);
    tick(1);  chk("clean_back_idle", busy, 0);
    tick(40); chk("clean_cnt", err_cnt, 0);
    write(32'h1000);
    corrupt({32'h1000, 32'h1100, 32'h1000});
    chk("single_warn", warn, 1);
    chk("single_vote", data, 32'h1000);
    tick(17);
    chk("single_fix_busy", busy, 1);
    chk("single_pre_cnt", err_cnt, 0);
    tick(1);
    chk("single_rep", rep, {3{32'h1000}});
    chk("single_warn_clr", warn, 0);
    chk("single_cnt", err_cnt, 1);
    chk("single_err_rep", err_rep, 3'b010);
    write(32'hA5A5);
    corrupt({32'hA5A7, 32'hA5A5, 32'hA5A4});
    chk("dbl_vote", data, 32'hA5A5);
    tick(18);
    chk("dbl_rep", rep, {3{32'hA5A5}});
    chk("dbl_cnt", err_cnt, 2);
    chk("dbl_err_rep", err_rep, 3'b111);
    write(32'h55);
    corrupt({32'h55, 32'h55, 32'h5A});
    tick(16);
    chk("wrchk_busy", busy, 1);
    wr_en = 1; wr_data = 32'hDEADBEEF; tick(1); wr_en = 0;
    chk("wrchk_rep", rep, {3{32'hDEADBEEF}});
    chk("wrchk_idle", busy, 0);
    chk("wrchk_cnt", err_cnt, 2);
    tick(15); chk("wrchk_timer_idle", busy, 0);
    tick(1);  chk("wrchk_timer_check", busy, 1);
    tick(1);
    clr = 1; tick(1); clr = 0;
    chk("clr_cnt", err_cnt, 0);
    chk("clr_err_rep", err_rep, 0);
    write(32'h77);
    corrupt({32'h77, 32'h76, 32'h77});
    tick(17);
    chk("wrfix_busy", busy, 1);
    wr_en = 1; wr_data = 32'h99; tick(1); wr_en = 0;
    chk("wrfix_rep", rep, {3{32'h99}});
    chk("wrfix_cnt", err_cnt, 0);
    chk("wrfix_err_rep", err_rep, 0);
`ifdef TMR_SCRUB_FAULT_INJ_EN
    write(32'h1000);
    inj = 3'b010; inj_mask = 32'h100; tick(1); inj = '0;
    chk("inj_warn", warn, 1);
    chk("inj_rep", rep, {32'h1000, 32'h1100, 32'h1000});
    tick(17);
    chk("inj_repaired", rep, {3{32'h1000}});
    chk("inj_err_rep", err_rep, 3'b010);
`endif
    write(32'h1234);
    corrupt({32'h1234, 32'h1234, 32'h1235});
    tick(17);
    chk("arst_busy_pre", busy, 1);
    rst_n = 0; #1;
    chk("arst_rep", rep, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", data, 0);
    chk("arst_warn", warn, 0);
    tick(1); rst_n = 1;
    wr2 = 1; wr_data2 = 8'h3C; tick(1); wr2 = 0;
    for (int i = 0; i < 5; i++) begin
      corrupt2({8'h3C, 8'h3C, 8'h3D});
      tick(6);
      chk("sat_cnt", err_cnt2, (i >= 2) ? 3 : i + 1);
    end
    chk("sat_rep", rep2, {3{8'h3C}});
    corrupt2({8'h3C, 8'hFC, 8'h3C});
    tick(5);
    chk("clrfix_busy", busy2, 1);
    clr2 = 1; tick(1); clr2 = 0;
    chk("clrfix_cnt", err_cnt2, 0);
    chk("clrfix_err_rep", err_rep2, 0);
    chk("clrfix_rep", rep2, {3{8'h3C}});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
